// File: rtl/rv32_decode_stage.sv
// rv32_decode_stage: registered RV32IM decode stage between fetch and execute.
// Splits raw instruction words into class, register indices, funct3, a
// sign-extended immediate, rd write-enable and an illegal flag. A 2-entry
// buffer (output register plus skid slot) keeps in_ready a flop.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   flush               drops every held and incoming instruction
//   in_valid/in_ready   fetch handshake; in_inst, in_pc instruction and its PC
//   out_valid/out_ready execute handshake
//   out_pc, out_class, out_funct3, out_alt, out_muldiv, out_rd, out_rs1,
//   out_rs2, out_we_rd, out_imm, out_illegal   decoded fields
module rv32_decode_stage #(
  parameter bit MEXT = 1'b1,
  parameter bit SKID = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [3:0]  out_class,
  output logic [2:0]  out_funct3,
  output logic        out_alt,
  output logic        out_muldiv,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic        out_we_rd,
  output logic [31:0] out_imm,
  output logic        out_illegal
);

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OPIMM  = 7'b0010011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  localparam logic [3:0] CLS_OP      = 4'd0;
  localparam logic [3:0] CLS_OPIMM   = 4'd1;
  localparam logic [3:0] CLS_BRANCH  = 4'd2;
  localparam logic [3:0] CLS_LOAD    = 4'd3;
  localparam logic [3:0] CLS_STORE   = 4'd4;
  localparam logic [3:0] CLS_LUI     = 4'd5;
  localparam logic [3:0] CLS_AUIPC   = 4'd6;
  localparam logic [3:0] CLS_JAL     = 4'd7;
  localparam logic [3:0] CLS_JALR    = 4'd8;
  localparam logic [3:0] CLS_ILLEGAL = 4'd15;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  cls;
    logic [2:0]  funct3;
    logic        alt;
    logic        muldiv;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        we_rd;
    logic [31:0] imm;
    logic        illegal;
  } dec_t;

  dec_t dec;
  dec_t out_q;
  dec_t skid_q;
  logic out_valid_q;
  logic skid_valid_q;
  logic skid_valid_n;
  logic in_ready_q;
  logic out_free;
  logic accept;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       writes_rd;

  assign opcode = in_inst[6:0];
  assign f3     = in_inst[14:12];
  assign f7     = in_inst[31:25];

  // Combinational decode of the word offered by fetch
  always_comb begin
    dec         = '0;
    writes_rd   = 1'b0;
    dec.pc      = in_pc;
    dec.funct3  = f3;
    dec.rd      = in_inst[11:7];
    dec.rs1     = in_inst[19:15];
    case (opcode)
      OP: begin
        dec.cls   = CLS_OP;
        dec.rs2   = in_inst[24:20];
        dec.alt   = in_inst[30];
        writes_rd = 1'b1;
        case (f7)
          F7_BASE: ;
          F7_ALT:  dec.illegal = (f3 != 3'b000) && (f3 != 3'b101);
          F7_MUL: begin
            dec.muldiv  = MEXT;
            dec.illegal = ~MEXT;
          end
          default: dec.illegal = 1'b1;
        endcase
      end
      OPIMM: begin
        dec.cls   = CLS_OPIMM;
        dec.imm   = {{20{in_inst[31]}}, in_inst[31:20]};
        writes_rd = 1'b1;
        // Shifts carry a 5-bit shamt; funct7 selects logical/arithmetic
        if (f3 == 3'b001) begin
          dec.imm     = {27'b0, in_inst[24:20]};
          dec.alt     = in_inst[30];
          dec.illegal = (f7 != F7_BASE);
        end else if (f3 == 3'b101) begin
          dec.imm     = {27'b0, in_inst[24:20]};
          dec.alt     = in_inst[30];
          dec.illegal = (f7 != F7_BASE) && (f7 != F7_ALT);
        end
      end
      BRANCH: begin
        dec.cls     = CLS_BRANCH;
        dec.rs2     = in_inst[24:20];
        dec.imm     = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                       in_inst[30:25], in_inst[11:8], 1'b0};
        dec.illegal = (f3 == 3'b010) || (f3 == 3'b011);
      end
      LOAD: begin
        dec.cls     = CLS_LOAD;
        dec.imm     = {{20{in_inst[31]}}, in_inst[31:20]};
        writes_rd   = 1'b1;
        dec.illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      STORE: begin
        dec.cls     = CLS_STORE;
        dec.rs2     = in_inst[24:20];
        dec.imm     = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
        dec.illegal = (f3 > 3'b010);
      end
      LUI: begin
        dec.cls   = CLS_LUI;
        dec.imm   = {in_inst[31:12], 12'b0};
        writes_rd = 1'b1;
      end
      AUIPC: begin
        dec.cls   = CLS_AUIPC;
        dec.imm   = {in_inst[31:12], 12'b0};
        writes_rd = 1'b1;
      end
      JAL: begin
        dec.cls   = CLS_JAL;
        dec.imm   = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                     in_inst[20], in_inst[30:21], 1'b0};
        writes_rd = 1'b1;
      end
      JALR: begin
        dec.cls     = CLS_JALR;
        dec.imm     = {{20{in_inst[31]}}, in_inst[31:20]};
        writes_rd   = 1'b1;
        dec.illegal = (f3 != 3'b000);
      end
      default: dec.illegal = 1'b1;
    endcase
    if (in_inst[1:0] != 2'b11) dec.illegal = 1'b1;
    dec.we_rd = writes_rd && (dec.rd != 5'd0);
    // Illegal words still travel as a normal beat, with side effects masked
    if (dec.illegal) begin
      dec.cls    = CLS_ILLEGAL;
      dec.we_rd  = 1'b0;
      dec.imm    = '0;
      dec.muldiv = 1'b0;
      dec.alt    = 1'b0;
    end
  end

  assign out_free = ~out_valid_q | out_ready;
  assign in_ready = SKID ? in_ready_q : (~reset & out_free);
  assign accept   = in_valid & in_ready & ~flush;

  // Skid occupancy after this cycle (flush/reset override in the register)
  always_comb begin
    skid_valid_n = skid_valid_q;
    if (out_free)    skid_valid_n = skid_valid_q & accept;
    else if (accept) skid_valid_n = 1'b1;
  end

  // Output register plus skid slot; skid always drains first to keep order
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      if (out_free) begin
        if (skid_valid_q) begin
          out_q       <= skid_q;
          out_valid_q <= 1'b1;
          if (accept) skid_q <= dec;
        end else if (accept) begin
          out_q       <= dec;
          out_valid_q <= 1'b1;
        end else begin
          out_valid_q <= 1'b0;
        end
      end else if (accept) begin
        skid_q <= dec;
      end
      skid_valid_q <= skid_valid_n;
      in_ready_q   <= ~skid_valid_n;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = out_q.pc;
  assign out_class   = out_q.cls;
  assign out_funct3  = out_q.funct3;
  assign out_alt     = out_q.alt;
  assign out_muldiv  = out_q.muldiv;
  assign out_rd      = out_q.rd;
  assign out_rs1     = out_q.rs1;
  assign out_rs2     = out_q.rs2;
  assign out_we_rd   = out_q.we_rd;
  assign out_imm     = out_q.imm;
  assign out_illegal = out_q.illegal;

endmodule
